// File: rtl/riscv_pkg.sv
// Shared RV32 fetch definitions: data width, sequencer state encoding and
// default reset/trap vectors.
package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALTED} pcseq_state_t;

  localparam logic [XLEN-1:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of the PC sequencer: imem request/response, IF/ID
// handshake, redirect from execute and halt control.
// trap_pulse exists only when MISALIGN_TRAP_EN is defined.
interface pc_sequencer_if;
  logic                      imem_req_valid;
  logic                      imem_req_ready;
  logic [riscv_pkg::XLEN-1:0] imem_addr;
  logic                      imem_rsp_valid;
  logic [riscv_pkg::XLEN-1:0] imem_rsp_data;
  logic                      if_valid;
  logic                      if_ready;
  logic [riscv_pkg::XLEN-1:0] if_pc;
  logic [riscv_pkg::XLEN-1:0] if_instr;
  logic                      redirect_valid;
  logic [riscv_pkg::XLEN-1:0] redirect_pc;
  logic                      halt_req;
  logic                      halted;
`ifdef MISALIGN_TRAP_EN
  logic                      trap_pulse;
`endif

  // Sequencer side
  modport master (
`ifdef MISALIGN_TRAP_EN
    output trap_pulse,
`endif
    output imem_req_valid, imem_addr, if_valid, if_pc, if_instr, halted,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
           redirect_valid, redirect_pc, halt_req
  );

  // Memory / decode / execute side
  modport slave (
`ifdef MISALIGN_TRAP_EN
    input  trap_pulse,
`endif
    input  imem_req_valid, imem_addr, if_valid, if_pc, if_instr, halted,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
           redirect_valid, redirect_pc, halt_req
  );
endinterface

// File: rtl/pc_plus4.sv
// Sequential-PC incrementer; wraps modulo 2^32 with no carry out.
module pc_plus4
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next
);
  assign pc_next = pc + 32'd4;
endmodule

// File: rtl/pc_sequencer.sv
// RV32 instruction-fetch sequencer: owns the PC, fetches one instruction at a
// time from imem and presents it to decode. Redirects override PC+4; a halt
// request parks the sequencer at an instruction boundary.
// Optional: MISALIGN_TRAP_EN turns misaligned redirect targets into a trap to
// TRAP_VECTOR with a one-cycle trap_pulse.
module pc_sequencer
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);
  pcseq_state_t    state, state_nx;
  logic [XLEN-1:0] pc, pc_nx, pc_inc;
  logic            squash, squash_nx;
  logic            capture;
  logic [XLEN-1:0] if_pc_q, if_instr_q;
  logic            misalign;
  logic [XLEN-1:0] redirect_target;

  pc_plus4 u_pc_plus4 (.pc(pc), .pc_next(pc_inc));

`ifdef MISALIGN_TRAP_EN
  assign misalign = |bus.redirect_pc[1:0];
`else
  // Low target bits are ignored; instructions are word aligned.
  logic unused_redirect_lo;
  assign unused_redirect_lo = |bus.redirect_pc[1:0];
  assign misalign = 1'b0;
`endif
  assign redirect_target = misalign ? TRAP_VECTOR : {bus.redirect_pc[XLEN-1:2], 2'b00};

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_addr      = pc;
  assign bus.if_valid       = (state == HOLD);
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;
  assign bus.halted         = (state == HALTED);

  // State, PC and squash registers; capture the response into the IF/ID slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      squash     <= 1'b0;
      if_pc_q    <= RESET_VECTOR;
      if_instr_q <= '0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      squash <= squash_nx;
      if (capture) begin
        if_pc_q    <= pc;
        if_instr_q <= bus.imem_rsp_data;
      end
    end
  end

  // Next-state logic. A redirect always wins the PC; anything fetched for the
  // old path is either dropped on arrival (squash) or discarded in HOLD.
  always_comb begin
    state_nx  = state;
    pc_nx     = pc;
    squash_nx = squash;
    capture   = 1'b0;
    case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        if (bus.imem_req_ready) begin
          state_nx = WAIT;
          // Request left with the old address; its data must not be used.
          if (bus.redirect_valid) squash_nx = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (squash || bus.redirect_valid) begin
            squash_nx = 1'b0;
            state_nx  = REQ;
          end else begin
            capture  = 1'b1;
            pc_nx    = pc_inc;
            state_nx = HOLD;
          end
        end else if (bus.redirect_valid) begin
          squash_nx = 1'b1;
        end
      end
      HOLD: begin
        if (bus.redirect_valid)  state_nx = REQ;
        else if (bus.if_ready)   state_nx = bus.halt_req ? HALTED : REQ;
      end
      HALTED: if (!bus.halt_req) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
    if (bus.redirect_valid) pc_nx = redirect_target;
  end

`ifdef MISALIGN_TRAP_EN
  logic trap_q;
  // One-cycle trap indication following a misaligned redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_q <= 1'b0;
    else        trap_q <= bus.redirect_valid & misalign;
  end
  assign bus.trap_pulse = trap_q;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: imem model with configurable latency,
// per-cycle event log, and a reference model based on architectural PC flow
// (next delivered PC = last redirect target, else previous delivered PC + 4).
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_sequencer_if bus();
  pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .TRAP_VECTOR(32'h0000_0100))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));

  typedef struct {
    bit          req_hs;
    logic [31:0] req_addr;
    bit          del_hs;
    logic [31:0] del_pc;
    logic [31:0] del_instr;
    bit          redir;
    logic [31:0] tgt;
    bit          ifv;
    bit          hlt;
    bit          trap;
    bit          viol;
  } rec_t;

  rec_t        log_q[$];
  int          n_cmp = 0, n_fail = 0;
  bit          pend = 0;
  logic [31:0] pend_addr;
  int          dly = 0;
  int          lat = 1;
  bit          rnd_lat = 0, rnd_ready = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] exp_tgt(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
    return (t[1:0] != 2'b00) ? 32'h0000_0100 : t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  // One clock of stimulus plus observation; imem responds in order.
  task automatic cycle(input bit redir, input logic [31:0] tgt, input bit halt, input bit ifr);
    rec_t r;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    if (pend) begin
      if (dly == 0) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem(pend_addr);
        pend = 0;
      end else dly--;
    end
    bus.imem_req_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.if_ready       = ifr;
    bus.redirect_valid = redir;
    bus.redirect_pc    = tgt;
    bus.halt_req       = halt;
    #1;
    r.viol     = bus.imem_req_valid && pend;
    r.req_hs   = bus.imem_req_valid && bus.imem_req_ready;
    r.req_addr = bus.imem_addr;
    if (r.req_hs) begin
      pend      = 1;
      pend_addr = bus.imem_addr;
      dly       = (rnd_lat ? int'($urandom_range(1, 3)) : lat) - 1;
    end
    r.del_hs    = bus.if_valid && ifr;
    r.del_pc    = bus.if_pc;
    r.del_instr = bus.if_instr;
    r.redir     = redir;
    r.tgt       = tgt;
    r.ifv       = bus.if_valid;
    r.hlt       = bus.halted;
`ifdef MISALIGN_TRAP_EN
    r.trap      = bus.trap_pulse;
`else
    r.trap      = 1'b0;
`endif
    log_q.push_back(r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
    bus.if_ready = 0; bus.redirect_valid = 0; bus.redirect_pc = '0; bus.halt_req = 0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.imem_req_valid, bus.if_valid, bus.halted} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 000", {bus.imem_req_valid, bus.if_valid, bus.halted});
    end
    n_cmp++;
    if (bus.imem_addr !== 32'h0 || bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_data addr=%h if_pc=%h instr=%h want 0", bus.imem_addr, bus.if_pc, bus.if_instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pend = 0;
  endtask

  // Straight-line fetch from the reset vector.
  task automatic test_sequential();
    logic [31:0] reqs[$], dels[$], ins[$];
    log_q.delete(); lat = 1; rnd_ready = 0; rnd_lat = 0;
    for (int i = 0; i < 40 && dels.size() < 3; i++) begin
      cycle(0, 32'h0, 0, 1);
      if (log_q[$].req_hs) reqs.push_back(log_q[$].req_addr);
      if (log_q[$].del_hs) begin dels.push_back(log_q[$].del_pc); ins.push_back(log_q[$].del_instr); end
    end
    n_cmp++;
    if (dels.size() != 3 || reqs.size() < 3) begin
      n_fail++; $display("FAIL seq_count got %0d deliveries %0d reqs want 3", dels.size(), reqs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (reqs[i] !== 32'(4 * i) || dels[i] !== 32'(4 * i) || ins[i] !== mem(32'(4 * i))) begin
          n_fail++; $display("FAIL seq_%0d req=%h pc=%h instr=%h want pc %h", i, reqs[i], dels[i], ins[i], 4 * i);
        end
      end
    end
  endtask

  // PC+4 wraps from the top of the address space to zero.
  task automatic test_wrap();
    logic [31:0] dels[$];
    logic [31:0] req_after;
    bit          got_req = 0;
    log_q.delete();
    cycle(1, 32'hFFFF_FFFC, 0, 1);
    for (int i = 0; i < 40 && !got_req; i++) begin
      cycle(0, 32'h0, 0, 1);
      if (log_q[$].del_hs) dels.push_back(log_q[$].del_pc);
      if (dels.size() > 0 && log_q[$].req_hs && !log_q[$].del_hs) begin req_after = log_q[$].req_addr; got_req = 1; end
    end
    n_cmp++;
    if (dels.size() < 1 || dels[0] !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_top got %0d deliveries first=%h want FFFFFFFC", dels.size(), dels.size() ? dels[0] : 32'hx);
    end
    n_cmp++;
    if (!got_req || req_after !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr got %h want 00000000", req_after);
    end
  endtask

  // Redirect while a fetch is outstanding: the old response must vanish.
  task automatic test_redirect_wait();
    bit          found = 0, bad = 0, got = 0;
    logic [31:0] first_pc, first_in;
    lat = 3;
    cycle(1, 32'h10, 0, 1);
    for (int i = 0; i < 30 && !found; i++) begin
      cycle(0, 32'h0, 0, 1);
      found = log_q[$].req_hs && log_q[$].req_addr == 32'h10;
    end
    log_q.delete();
    cycle(1, 32'h200, 0, 1);
    for (int i = 0; i < 40 && !got; i++) begin
      cycle(0, 32'h0, 0, 1);
      if (log_q[$].del_hs) begin
        got = 1; first_pc = log_q[$].del_pc; first_in = log_q[$].del_instr;
        if (first_pc == 32'h10) bad = 1;
      end
    end
    n_cmp++;
    if (!found || !got || bad || first_pc !== 32'h200 || first_in !== mem(32'h200)) begin
      n_fail++; $display("FAIL redirect_wait found=%0d got=%0d pc=%h instr=%h want pc 00000200", found, got, first_pc, first_in);
    end
    lat = 1;
  endtask

  // Redirect in HOLD beats a simultaneous decode accept.
  task automatic test_redirect_hold();
    bit          seen = 0, got = 0;
    logic [31:0] first_pc;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle(0, 32'h0, 0, 0);
      seen = log_q[$].ifv;
    end
    cycle(1, 32'h80, 0, 1);
    cycle(0, 32'h0, 0, 1);
    n_cmp++;
    if (!seen || log_q[$].ifv !== 1'b0) begin
      n_fail++; $display("FAIL redirect_hold_valid seen=%0d if_valid=%b want 0", seen, log_q[$].ifv);
    end
    if (log_q[$].del_hs) begin got = 1; first_pc = log_q[$].del_pc; end
    for (int i = 0; i < 30 && !got; i++) begin
      cycle(0, 32'h0, 0, 1);
      if (log_q[$].del_hs) begin got = 1; first_pc = log_q[$].del_pc; end
    end
    n_cmp++;
    if (!got || first_pc !== 32'h80) begin
      n_fail++; $display("FAIL redirect_hold_pc got %h want 00000080", first_pc);
    end
  endtask

  // Halt raised mid-fetch: the fetch completes, then no requests until release.
  task automatic test_halt();
    bit          hs = 0, got = 0, ok = 1, resumed = 0;
    logic [31:0] a, dpc, raddr;
    lat = 2;
    for (int i = 0; i < 30 && !hs; i++) begin
      cycle(0, 32'h0, 0, 1);
      hs = log_q[$].req_hs; a = log_q[$].req_addr;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(0, 32'h0, 1, 1);
      if (log_q[$].del_hs) begin got = 1; dpc = log_q[$].del_pc; end
    end
    n_cmp++;
    if (!hs || !got || dpc !== a) begin
      n_fail++; $display("FAIL halt_deliver got pc %h want %h", dpc, a);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(0, 32'h0, 1, 1);
      if (!log_q[$].hlt || log_q[$].req_hs) ok = 0;
    end
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL halt_hold halted=%b req=%b want halted 1 req 0", log_q[$].hlt, log_q[$].req_hs);
    end
    for (int i = 0; i < 10 && !resumed; i++) begin
      cycle(0, 32'h0, 0, 1);
      if (log_q[$].req_hs) begin resumed = 1; raddr = log_q[$].req_addr; end
    end
    n_cmp++;
    if (!resumed || raddr !== a + 32'd4) begin
      n_fail++; $display("FAIL halt_resume got %h want %h", raddr, a + 32'd4);
    end
    lat = 1;
  endtask

  // Misaligned redirect: trap vector with the macro, word-masked without.
  task automatic test_misaligned();
    bit          got = 0;
    int          traps = 0;
    logic [31:0] raddr;
    log_q.delete();
    cycle(1, 32'h102, 0, 1);
    for (int i = 0; i < 30 && !got; i++) begin
      cycle(0, 32'h0, 0, 1);
      if (log_q[$].req_hs) begin got = 1; raddr = log_q[$].req_addr; end
    end
    repeat (3) cycle(0, 32'h0, 0, 1);
    n_cmp++;
    if (!got || raddr !== 32'h100) begin
      n_fail++; $display("FAIL misalign_addr got %h want 00000100", raddr);
    end
    foreach (log_q[i]) if (log_q[i].trap) traps++;
`ifdef MISALIGN_TRAP_EN
    n_cmp++;
    if (traps != 1 || !log_q[1].trap) begin
      n_fail++; $display("FAIL trap_pulse got %0d pulses want 1 in cycle after redirect", traps);
    end
`endif
  endtask

  // Random readiness, latency and redirects against the PC-flow model.
  task automatic test_random();
    logic [31:0] exp_pc, t;
    int          ndel = 0, nviol = 0;
    log_q.delete(); rnd_ready = 1; rnd_lat = 1;
    t = $urandom;
    cycle(1, t, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(($urandom_range(0, 11) == 0), t, 0, 1'($urandom_range(0, 1)));
    end
    foreach (log_q[i]) begin
      if (log_q[i].viol) nviol++;
      if (log_q[i].del_hs && !log_q[i].redir) begin
        ndel++;
        n_cmp++;
        if (log_q[i].del_pc !== exp_pc || log_q[i].del_instr !== mem(exp_pc)) begin
          n_fail++; $display("FAIL random_deliver #%0d pc=%h instr=%h want pc=%h instr=%h",
                             ndel, log_q[i].del_pc, log_q[i].del_instr, exp_pc, mem(exp_pc));
        end
        exp_pc = log_q[i].del_pc + 32'd4;
      end
      if (log_q[i].redir) exp_pc = exp_tgt(log_q[i].tgt);
    end
    n_cmp++;
    if (nviol != 0) begin
      n_fail++; $display("FAIL random_outstanding got %0d overlapping requests want 0", nviol);
    end
    n_cmp++;
    if (ndel < 50) begin
      n_fail++; $display("FAIL random_progress got %0d deliveries want >= 50", ndel);
    end
    rnd_ready = 0; rnd_lat = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_redirect_wait();
    test_redirect_hold();
    test_halt();
    test_misaligned();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
